// File: rtl/nes_run_ctrl_if.sv
// Command handshake bundle for nes_run_ctrl: valid/ready transfer of an opcode and step count.
interface nes_run_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/nes_run_ctrl.sv
// Run/pause/step controller gating the NES clock divider. Breakpoint halting is
// built in only when NES_RUN_CTRL_BREAKPOINT_EN is defined.
module nes_run_ctrl #(
    parameter int DIV   = 24,
    parameter int CNT_W = 16
) (
    input  logic          clk_master,
    input  logic          rst_master_n,
    nes_run_ctrl_if.slave cmd,
    input  logic          vsync,
    input  logic          bp_hit,
    output logic          en,
    output logic [4:0]    phase,
    output logic          running,
    output logic          done,
    output logic          cmd_err,
    output logic          bp_halted
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_FRAME = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [2:0] OP_PAUSE      = 3'd0;
    localparam logic [2:0] OP_RUN        = 3'd1;
    localparam logic [2:0] OP_STEP_MCLK  = 3'd2;
    localparam logic [2:0] OP_STEP_CPU   = 3'd3;
    localparam logic [2:0] OP_STEP_FRAME = 3'd4;

    localparam logic [4:0] LAST_PHASE = 5'(DIV - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_cpu_q, step_cpu_d;
    logic             vsync_q;
    logic             done_d, err_d, bp_halted_d;
    logic             accept, wrap, vs_rise, bp_req;
    logic [CNT_W-1:0] arg_eff;

    assign running       = (state_q != S_IDLE);
    assign cmd.cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign wrap          = en && (phase == LAST_PHASE);
    assign vs_rise       = vsync && !vsync_q;
    assign arg_eff       = (cmd.cmd_arg == '0) ? CNT_W'(1) : cmd.cmd_arg;

`ifdef NES_RUN_CTRL_BREAKPOINT_EN
    assign bp_req = bp_hit;
`else
    // Tied off so the port stays connected and bp_halted can never set.
    assign bp_req = bp_hit & 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_cpu_d  = step_cpu_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bp_halted_d = bp_halted;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    bp_halted_d = 1'b0;
                    case (cmd.cmd_op)
                        OP_PAUSE:      done_d  = 1'b1;
                        OP_RUN:        state_d = S_RUN;
                        OP_STEP_MCLK: begin
                            state_d    = S_STEP;
                            cnt_d      = arg_eff;
                            step_cpu_d = 1'b0;
                        end
                        OP_STEP_CPU: begin
                            state_d    = S_STEP;
                            cnt_d      = arg_eff;
                            step_cpu_d = 1'b1;
                        end
                        OP_STEP_FRAME: state_d = S_FRAME;
                        default:       err_d   = 1'b1;
                    endcase
                end
            end

            S_RUN: begin
                if (bp_req) begin
                    state_d     = S_DRAIN;
                    bp_halted_d = 1'b1;
                end else if (accept) begin
                    if (cmd.cmd_op == OP_PAUSE) begin
                        // Pausing on the wrap cycle already lands on a CPU boundary.
                        if (wrap) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_STEP: begin
                if (bp_req) begin
                    state_d     = S_DRAIN;
                    bp_halted_d = 1'b1;
                end else if (!step_cpu_q || wrap) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_FRAME: begin
                if (bp_req) begin
                    state_d     = S_DRAIN;
                    bp_halted_d = 1'b1;
                end else if (vs_rise) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (wrap) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_master or negedge rst_master_n) begin
        if (!rst_master_n) begin
            state_q    <= S_IDLE;
            en         <= 1'b0;
            phase      <= '0;
            cnt_q      <= '0;
            step_cpu_q <= 1'b0;
            vsync_q    <= 1'b0;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
            bp_halted  <= 1'b0;
        end else begin
            state_q    <= state_d;
            en         <= (state_d != S_IDLE);
            if (en) begin
                phase <= wrap ? '0 : phase + 5'd1;
            end
            cnt_q      <= cnt_d;
            step_cpu_q <= step_cpu_d;
            vsync_q    <= vsync;
            done       <= done_d;
            cmd_err    <= err_d;
            bp_halted  <= bp_halted_d;
        end
    end
endmodule

// File: tb/tb_nes_run_ctrl.sv
// Self-checking bench for nes_run_ctrl: expected enable lengths and end phases come
// from cycle arithmetic on the divider period, not from the controller's state machine.
module tb_nes_run_ctrl;
    localparam int DIV   = 24;
    localparam int CNT_W = 16;

    localparam logic [2:0] OP_PAUSE      = 3'd0;
    localparam logic [2:0] OP_RUN        = 3'd1;
    localparam logic [2:0] OP_STEP_MCLK  = 3'd2;
    localparam logic [2:0] OP_STEP_CPU   = 3'd3;
    localparam logic [2:0] OP_STEP_FRAME = 3'd4;

`ifdef NES_RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       vsync;
    logic       bp_hit;
    logic       en;
    logic [4:0] phase;
    logic       running;
    logic       done;
    logic       cmd_err;
    logic       bp_halted;

    int checks;
    int failures;
    int mphase;   // model of the divider phase while the controller sits idle

    nes_run_ctrl_if #(.CNT_W(CNT_W)) cmd_if ();

    nes_run_ctrl #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk_master   (clk),
        .rst_master_n (rst_n),
        .cmd          (cmd_if),
        .vsync        (vsync),
        .bp_hit       (bp_hit),
        .en           (en),
        .phase        (phase),
        .running      (running),
        .done         (done),
        .cmd_err      (cmd_err),
        .bp_halted    (bp_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [2:0] op, input int arg);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = CNT_W'(arg);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd0;
        cmd_if.cmd_arg   = '0;
    endtask

    task automatic issue(input logic [2:0] op, input int arg);
        @(negedge clk);
        drive(op, arg);
    endtask

    // Counts enable-high cycles until the first idle cycle, plus pulses seen along the way.
    task automatic count_until_idle(output int n_en, output int n_done, output int n_err,
                                    output int end_phase, output bit timeout);
        n_en = 0; n_done = 0; n_err = 0; end_phase = -1; timeout = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done)    n_done++;
            if (cmd_err) n_err++;
            if (en) n_en++;
            else begin
                end_phase = int'(phase);
                timeout   = 1'b0;
                break;
            end
        end
        @(negedge clk);
        if (done) n_done++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++; if (en !== 1'b0)        begin failures++; $display("FAIL reset_en got=%b exp=0", en); end
        checks++; if (phase !== 5'd0)     begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        checks++; if (running !== 1'b0)   begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (cmd_err !== 1'b0)   begin failures++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
        checks++; if (bp_halted !== 1'b0) begin failures++; $display("FAIL reset_bp_halted got=%b exp=0", bp_halted); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_if.cmd_ready); end
        @(negedge clk);
        rst_n  = 1'b1;
        mphase = 0;
    endtask

    task automatic test_step_cpu3;
        int n_en, n_done, n_err, ph;
        bit to;
        issue(OP_STEP_CPU, 3);
        count_until_idle(n_en, n_done, n_err, ph, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL cpu3_timeout got=%b exp=0", to); end
        checks++; if (n_en != 72)  begin failures++; $display("FAIL cpu3_en_cycles got=%0d exp=72", n_en); end
        checks++; if (ph != 0)     begin failures++; $display("FAIL cpu3_end_phase got=%0d exp=0", ph); end
        checks++; if (n_done != 1) begin failures++; $display("FAIL cpu3_done_pulses got=%0d exp=1", n_done); end
        mphase = 0;
    endtask

    task automatic test_step_mixed;
        int n_en, n_done, n_err, ph, nn, exp_en, exp_ph, arg;
        bit to;
        logic [2:0] op;
        for (int it = 0; it < 14; it++) begin
            if (it == 0)      begin op = OP_STEP_MCLK; arg = 5; end
            else if (it == 1) begin op = OP_STEP_CPU;  arg = 1; end
            else if (it == 2) begin op = OP_STEP_CPU;  arg = 0; end
            else if (it == 3) begin op = OP_STEP_MCLK; arg = 0; end
            else if ($urandom_range(0, 1) == 0) begin op = OP_STEP_MCLK; arg = int'($urandom_range(0, 60)); end
            else begin op = OP_STEP_CPU; arg = int'($urandom_range(0, 3)); end
            nn = (arg == 0) ? 1 : arg;
            if (op == OP_STEP_MCLK) begin
                exp_en = nn;
                exp_ph = (mphase + nn) % DIV;
            end else begin
                exp_en = (DIV - mphase) + (nn - 1) * DIV;
                exp_ph = 0;
            end
            issue(op, arg);
            count_until_idle(n_en, n_done, n_err, ph, to);
            checks++; if (n_en != exp_en) begin failures++; $display("FAIL step_en_cycles it=%0d op=%0d arg=%0d got=%0d exp=%0d", it, op, arg, n_en, exp_en); end
            checks++; if (ph != exp_ph)   begin failures++; $display("FAIL step_end_phase it=%0d got=%0d exp=%0d", it, ph, exp_ph); end
            checks++; if (n_done != 1)    begin failures++; $display("FAIL step_done it=%0d got=%0d exp=1", it, n_done); end
            mphase = exp_ph;
        end
    endtask

    task automatic test_run_pause;
        int n_en, n_done, n_err, ph, p, k, exp_en;
        bit to;
        for (int it = 0; it < 8; it++) begin
            if (it == 0)      p = 10;
            else if (it == 1) p = DIV - 1;
            else if (it == 2) p = 0;
            else              p = int'($urandom_range(0, DIV - 1));
            issue(OP_RUN, 0);
            k = (p - mphase + DIV) % DIV;
            repeat (k + 1) @(negedge clk);
            checks++; if (int'(phase) != p || en !== 1'b1) begin failures++; $display("FAIL run_phase it=%0d got=%0d/%b exp=%0d/1", it, phase, en, p); end
            drive(OP_PAUSE, 0);
            exp_en = (p == DIV - 1) ? 0 : DIV - 1 - p;
            count_until_idle(n_en, n_done, n_err, ph, to);
            checks++; if (n_en != exp_en) begin failures++; $display("FAIL pause_drain it=%0d p=%0d got=%0d exp=%0d", it, p, n_en, exp_en); end
            checks++; if (ph != 0)        begin failures++; $display("FAIL pause_end_phase it=%0d got=%0d exp=0", it, ph); end
            checks++; if (n_done != 1)    begin failures++; $display("FAIL pause_done it=%0d got=%0d exp=1", it, n_done); end
            mphase = 0;
        end
        issue(OP_PAUSE, 0);
        count_until_idle(n_en, n_done, n_err, ph, to);
        checks++; if (n_en != 0 || n_done != 1) begin failures++; $display("FAIL idle_pause got=en%0d/done%0d exp=en0/done1", n_en, n_done); end
    endtask

    task automatic test_frame;
        int n_en, n_done, n_err, ph, d, q, exp_en;
        bit to;
        for (int it = 0; it < 4; it++) begin
            d = (it == 0) ? 1000 : int'($urandom_range(0, 60));
            issue(OP_STEP_FRAME, 0);
            repeat (d + 1) @(negedge clk);
            q = (mphase + d) % DIV;
            checks++; if (en !== 1'b1 || int'(phase) != q) begin failures++; $display("FAIL frame_wait it=%0d got=%b/%0d exp=1/%0d", it, en, phase, q); end
            vsync = 1'b1;
            count_until_idle(n_en, n_done, n_err, ph, to);
            vsync = 1'b0;
            exp_en = DIV - ((q + 1) % DIV);
            checks++; if (n_en != exp_en) begin failures++; $display("FAIL frame_drain it=%0d q=%0d got=%0d exp=%0d", it, q, n_en, exp_en); end
            checks++; if (ph != 0 || n_done != 1) begin failures++; $display("FAIL frame_end it=%0d got=ph%0d/done%0d exp=ph0/done1", it, ph, n_done); end
            mphase = 0;
        end
    endtask

    task automatic test_breakpoint;
        int n_en, n_done, n_err, ph, k, p;
        bit to;
        issue(OP_RUN, 0);
        k = (4 - mphase + DIV) % DIV;
        repeat (k + 1) @(negedge clk);
        bp_hit = 1'b1;
        @(posedge clk);
        #1;
        bp_hit = 1'b0;
        if (BP_EN) begin
            count_until_idle(n_en, n_done, n_err, ph, to);
            checks++; if (n_en != DIV - 5) begin failures++; $display("FAIL bp_drain got=%0d exp=%0d", n_en, DIV - 5); end
            checks++; if (ph != 0 || n_done != 1) begin failures++; $display("FAIL bp_end got=ph%0d/done%0d exp=ph0/done1", ph, n_done); end
            checks++; if (bp_halted !== 1'b1) begin failures++; $display("FAIL bp_halted_set got=%b exp=1", bp_halted); end
            issue(OP_PAUSE, 0);
            @(negedge clk);
            checks++; if (bp_halted !== 1'b0) begin failures++; $display("FAIL bp_halted_clear got=%b exp=0", bp_halted); end
        end else begin
            repeat (30) @(negedge clk);
            checks++; if (en !== 1'b1 || running !== 1'b1) begin failures++; $display("FAIL bp_ignored got=%b exp=1", en); end
            checks++; if (bp_halted !== 1'b0) begin failures++; $display("FAIL bp_halted_off got=%b exp=0", bp_halted); end
            p = (4 + 30) % DIV;
            drive(OP_PAUSE, 0);
            count_until_idle(n_en, n_done, n_err, ph, to);
            checks++; if (n_en != DIV - 1 - p || n_done != 1) begin failures++; $display("FAIL bp_off_pause got=en%0d/done%0d exp=en%0d/done1", n_en, n_done, DIV - 1 - p); end
        end
        mphase = 0;
    endtask

    task automatic test_cmd_err;
        int n_en, n_done, n_err, ph, errs, lows, p;
        bit to;
        logic [2:0] rop;
        issue(OP_RUN, 0);
        p = mphase;
        issue(OP_STEP_CPU, 2);
        errs = 0; lows = 0;
        repeat (5) begin
            @(negedge clk);
            if (cmd_err) errs++;
            if (en !== 1'b1) lows++;
        end
        checks++; if (errs != 1) begin failures++; $display("FAIL run_step_err got=%0d exp=1", errs); end
        checks++; if (lows != 0) begin failures++; $display("FAIL run_continues got=%0d low cycles exp=0", lows); end
        rop = 3'(5 + $urandom_range(0, 2));
        issue(rop, 7);
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (cmd_err) errs++;
        end
        checks++; if (errs != 1 || en !== 1'b1) begin failures++; $display("FAIL run_reserved_err got=%0d/%b exp=1/1", errs, en); end
        p = (p + 12) % DIV;
        issue(OP_PAUSE, 0);
        count_until_idle(n_en, n_done, n_err, ph, to);
        checks++; if (n_en != ((p == DIV - 1) ? 0 : DIV - 1 - p)) begin failures++; $display("FAIL err_pause_drain got=%0d p=%0d", n_en, p); end
        mphase = 0;
        issue(rop, 3);
        errs = 0; lows = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_err) errs++;
            if (en !== 1'b0) lows++;
        end
        checks++; if (errs != 1 || lows != 0) begin failures++; $display("FAIL idle_reserved got=err%0d/en_hi%0d exp=err1/en_hi0", errs, lows); end
    endtask

    task automatic test_reset_mid_step;
        issue(OP_STEP_CPU, 5);
        repeat (30) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (en !== 1'b0 || phase !== 5'd0) begin failures++; $display("FAIL async_reset got=en%b/ph%0d exp=en0/ph0", en, phase); end
        checks++; if (running !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL async_reset_state got=run%b/rdy%b exp=run0/rdy1", running, cmd_if.cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(OP_STEP_MCLK, 3);
        @(negedge clk);
        checks++; if (en !== 1'b1) begin failures++; $display("FAIL first_edge_accept got=%b exp=1", en); end
        repeat (4) @(negedge clk);
        checks++; if (en !== 1'b0 || phase !== 5'd3 || done !== 1'b0) begin failures++; $display("FAIL post_reset_step got=en%b/ph%0d exp=en0/ph3", en, phase); end
        mphase = 3;
    endtask

    initial begin
        checks = 0; failures = 0; mphase = 0;
        rst_n = 1'b0; vsync = 1'b0; bp_hit = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 3'd0; cmd_if.cmd_arg = '0;
        test_reset;
        test_step_cpu3;
        test_step_mixed;
        test_run_pause;
        test_frame;
        test_breakpoint;
        test_cmd_err;
        test_reset_mid_step;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nes_run_ctrl.md
NES_RUN_CTRL -- requirements
Module: nes_run_ctrl

Interface
REQ-001 Parameter DIV, default 24: master clocks per CPU cycle; the phase counter wraps at DIV-1.
REQ-002 Parameter CNT_W, default 16: width of cmd_arg and of the step counter.
REQ-003 clk_master  in  1  sole clock; all logic on posedge.
REQ-004 rst_master_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command can be accepted; transfer happens when cmd_valid and cmd_ready are both 1.
REQ-007 cmd_op  in  3  command code: 0 PAUSE, 1 RUN, 2 STEP_MCLK, 3 STEP_CPU, 4 STEP_FRAME; codes 5-7 are reserved.
REQ-008 cmd_arg  in  CNT_W  step count for STEP_MCLK and STEP_CPU.
REQ-009 vsync  in  1  PPU frame-start level, synchronous to clk_master.
REQ-010 bp_hit  in  1  breakpoint request, synchronous to clk_master.
REQ-011 en  out  1  registered enable to the NES clock divider.
REQ-012 phase  out  5  mirror of the divider count, 0..DIV-1.
REQ-013 running  out  1  1 in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a step, pause or breakpoint halt completes.
REQ-015 cmd_err  out  1  one-cycle pulse when a command is rejected.
REQ-016 bp_halted  out  1  sticky flag: the last halt was caused by a breakpoint.

Function
REQ-017 States: IDLE, RUN, STEP (covers MCLK and CPU stepping), FRAME, DRAIN; en = 1 exactly when the state is not IDLE.
REQ-018 phase increments every cycle in which en = 1 and wraps DIV-1 -> 0; a "wrap" is any cycle where en = 1 and phase = DIV-1.
REQ-019 cmd_ready = 1 in IDLE and RUN, and 0 in STEP, FRAME and DRAIN.
REQ-020 Latency: for a command accepted in cycle t, the first cycle with en = 1 is t+1.
REQ-021 IDLE + RUN -> RUN.
REQ-022 IDLE + STEP_MCLK N -> STEP; en is high for exactly max(N,1) cycles, then the block returns to IDLE and pulses done in the first IDLE cycle.
REQ-023 IDLE + STEP_CPU N -> STEP; the counter is loaded with max(N,1) and decrements on each wrap; the block leaves for IDLE on the wrap that takes the counter to 0.
REQ-024 IDLE + STEP_FRAME -> FRAME; a rising edge on vsync (sampled against the previous cycle) moves FRAME -> DRAIN.
REQ-025 DRAIN holds en = 1 until the next wrap, then goes to IDLE with a done pulse.
REQ-026 RUN + PAUSE -> DRAIN; if phase = DIV-1 in that same cycle, the block goes directly to IDLE and pulses done.
REQ-027 IDLE + PAUSE: accepted with no state change, done pulses on the next cycle.
REQ-028 RUN + any op other than PAUSE, and any reserved op in any state: the command is consumed and cmd_err pulses the next cycle; the state is unchanged.
REQ-029 A command accepted in IDLE clears bp_halted.
REQ-030 A vsync edge and a bp_hit in the same cycle: the breakpoint takes priority.

Reset
REQ-031 Asserting rst_master_n low, at any time including mid-step, forces the following immediately, without waiting for a clock edge:
- state IDLE
- en = 0, phase = 0, running = 0
- done = 0, cmd_err = 0, bp_halted = 0
- cmd_ready = 1
- step counter = 0, stored vsync sample = 0
REQ-032 After reset deasserts, the first command can be accepted on the first clock edge.

Configuration
REQ-033 Macro NES_RUN_CTRL_BREAKPOINT_EN.
- Defined: bp_hit = 1 in RUN, STEP or FRAME moves the block to DRAIN and sets bp_halted.
- Not defined: bp_hit is ignored and bp_halted is held at 0.
- The port list is identical in both builds.

Verification
REQ-034 From reset, issue STEP_CPU with arg 3 -> en is high for exactly 72 consecutive cycles, phase ends at 0, and done pulses once.
REQ-035 Issue STEP_MCLK with arg 5 -> en is high for 5 cycles and phase = 5; then STEP_CPU with arg 1 -> en is high for 19 cycles and phase ends at 0.
REQ-036 Issue RUN, then PAUSE when phase = 10 -> en stays high until phase 23 has elapsed, then IDLE with phase = 0 and done pulsing once.
REQ-037 Issue STEP_FRAME and raise vsync 1000 cycles later -> the block drains to the next wrap and returns to IDLE; STEP_CPU with arg 0 behaves exactly like arg 1.
REQ-038 With the macro defined, issue RUN and pulse bp_hit when phase = 4 -> DRAIN, IDLE after 20 more cycles, bp_halted = 1; the next accepted command clears it. Without the macro -> the block keeps running.
REQ-039 Issue STEP_CPU while in RUN -> cmd_err pulses once and RUN continues; drop rst_master_n mid-STEP -> en = 0 and phase = 0 with no clock edge required.
